can_tx_fifo: RTL and testbench

- Transmit-side frame buffer of the CAN controller.
- The host/register block writes a frame as 32-bit words, then commits it. The CAN bit-stream transmitter reads committed frames word by word.
- The transmitter then releases the frame on success or abort, or rewinds it for retransmission after arbitration loss or error.
- Word storage plus a per-frame length FIFO. Mirror image of the receive FIFO.

---
 rtl/can_tx_pkg.sv | 16 +
 rtl/can_tx_len_fifo.sv | 53 +++++
 rtl/can_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_can_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_pkg.sv
// Shared types and default sizing for the CAN transmit frame buffer.
package can_tx_pkg;

  localparam int DEF_DEPTH           = 64;
  localparam int DEF_INFO_DEPTH      = 16;
  localparam int DEF_MAX_FRAME_WORDS = 18;
  localparam int LEN_W               = $clog2(DEF_MAX_FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_READY     = 2'd1,
    TX_READING   = 2'd2,
    TX_DONE_WAIT = 2'd3
  } tx_state_t;

endpackage

// File: rtl/can_tx_len_fifo.sv
// Synchronous FIFO of committed frame lengths; head is read combinationally.
module can_tx_len_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rp_q];
  assign count_o = cnt_q;

  always_comb begin
    wp_d  = wp_q + AW'(do_push);
    rp_d  = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst | clear_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/can_tx_fifo.sv
// CAN transmit frame buffer: host stages and commits frames, the transmitter
// reads them word by word and releases or rewinds the head frame.
module can_tx_fifo
  import can_tx_pkg::*;
#(
  parameter int DEPTH           = DEF_DEPTH,
  parameter int INFO_DEPTH      = DEF_INFO_DEPTH,
  parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reset_mode,
  input  logic                        wr,
  input  logic [31:0]                 data_in,
  input  logic                        commit,
  output logic                        tx_req,
  input  logic                        rd,
  output logic [31:0]                 data_out,
  output logic                        last_word,
  input  logic                        tx_release,
  input  logic                        tx_rewind,
  output logic                        overrun,
  output logic [$clog2(INFO_DEPTH):0] info_cnt,
  output logic [$clog2(DEPTH):0]      free_words,
  output logic [1:0]                  tx_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(INFO_DEPTH);
  localparam int LW = $clog2(MAX_FRAME_WORDS + 1);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx, frame_start_q, frame_start_d;
  logic [AW-1:0] rd_ptr_q, rd_addr;
  logic [LW-1:0] frame_len_q, frame_len_d, frame_len_nx, rd_off_q, head_len;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic [IW:0]   info_cnt_nx;
  logic          drop_q, drop_d, ovr_q, ovr_d;
  logic          info_full, info_empty;
  logic          wr_acc, wr_rej, drop_eff, len_nz, commit_ok, discard;
  logic          release_ok, rewind_ok, rd_ok;
  tx_state_t     state_q;

  // A word rejected in the same cycle as commit poisons the frame just like a held drop.
  always_comb begin
    wr_acc       = wr & (word_cnt_q != (AW+1)'(DEPTH))
                   & (frame_len_q < LW'(MAX_FRAME_WORDS)) & ~drop_q;
    wr_rej       = wr & ~wr_acc;
    drop_eff     = drop_q | wr_rej;
    frame_len_nx = frame_len_q + LW'(wr_acc);
    wr_ptr_nx    = wr_ptr_q + AW'(wr_acc);
    len_nz       = (frame_len_nx != '0);
    commit_ok    = commit & len_nz & ~drop_eff & ~info_full;
    discard      = commit & (drop_eff | (info_full & len_nz));
    release_ok   = tx_req & tx_release;
    rewind_ok    = tx_req & tx_rewind & ~tx_release;
    rd_ok        = tx_req & rd & ~tx_release & ~tx_rewind;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_nx;
    frame_start_d = frame_start_q;
    frame_len_d   = frame_len_nx;
    drop_d        = drop_eff;
    ovr_d         = ovr_q | wr_rej;
    if (commit_ok) begin
      frame_start_d = wr_ptr_nx;
      frame_len_d   = '0;
    end else if (discard) begin
      wr_ptr_d    = frame_start_q;
      frame_len_d = '0;
      drop_d      = 1'b0;
      ovr_d       = 1'b1;
    end
    word_cnt_d  = word_cnt_q + (AW+1)'(wr_acc)
                  - (release_ok ? (AW+1)'(head_len) : '0)
                  - (discard ? (AW+1)'(frame_len_nx) : '0);
    info_cnt_nx = info_cnt + (IW+1)'(commit_ok) - (IW+1)'(release_ok);
  end

  always_ff @(posedge clk) begin
    if (rst | reset_mode) begin
      wr_ptr_q      <= '0;
      frame_start_q <= '0;
      frame_len_q   <= '0;
      word_cnt_q    <= '0;
      drop_q        <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      frame_len_q   <= frame_len_d;
      word_cnt_q    <= word_cnt_d;
      drop_q        <= drop_d;
      ovr_q         <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc & ~rst & ~reset_mode) mem_q[wr_ptr_q] <= data_in;
  end

  can_tx_len_fifo #(.DEPTH(INFO_DEPTH), .W(LW)) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (reset_mode),
    .push_i  (commit_ok),
    .pop_i   (release_ok),
    .din_i   (frame_len_nx),
    .head_o  (head_len),
    .count_o (info_cnt),
    .full_o  (info_full),
    .empty_o (info_empty)
  );

  // Leaving TX_IDLE on the commit edge itself makes tx_req track info_cnt != 0.
  always_ff @(posedge clk) begin
    if (rst | reset_mode) begin
      state_q  <= TX_IDLE;
      rd_ptr_q <= '0;
      rd_off_q <= '0;
    end else if (release_ok) begin
      rd_ptr_q <= rd_ptr_q + AW'(head_len);
      rd_off_q <= '0;
      state_q  <= (info_cnt_nx != '0) ? TX_READY : TX_IDLE;
    end else if (rewind_ok) begin
      rd_off_q <= '0;
      state_q  <= TX_READY;
    end else begin
      case (state_q)
        TX_IDLE: if (commit_ok | ~info_empty) state_q <= TX_READY;
        TX_READY: if (rd_ok) begin
          if (head_len == LW'(1)) state_q <= TX_DONE_WAIT;
          else begin
            rd_off_q <= LW'(1);
            state_q  <= TX_READING;
          end
        end
        TX_READING: if (rd_ok) begin
          if (last_word) state_q <= TX_DONE_WAIT;
          else rd_off_q <= rd_off_q + LW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rd_addr    = rd_ptr_q + AW'(rd_off_q);
  assign data_out   = mem_q[rd_addr];
  assign tx_req     = (state_q != TX_IDLE);
  assign last_word  = tx_req & (rd_off_q == head_len - LW'(1));
  assign overrun    = ovr_q;
  assign free_words = (AW+1)'(DEPTH) - word_cnt_q;
  assign tx_state_o = state_q;

endmodule

// File: tb/tb_can_tx_fifo.sv
// Self-checking bench for can_tx_fifo: directed scenarios plus a random run
// against a queue-based model of committed frames and staged words.
module tb_can_tx_fifo;
  import can_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0, reset_mode = 1'b0, wr = 1'b0, commit = 1'b0;
  logic        rd = 1'b0, tx_release = 1'b0, tx_rewind = 1'b0;
  logic [31:0] data_in = '0, data_out;
  logic        tx_req, last_word, overrun;
  logic [4:0]  info_cnt;
  logic [6:0]  free_words;
  logic [1:0]  tx_state_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model: exp_q holds committed words in order, len_q the frame lengths,
  // stg_q the words of the frame being staged.
  logic [31:0] exp_q[$];
  logic [31:0] stg_q[$];
  int          len_q[$];
  bit          m_drop, m_ovr;
  int          m_off;

  always #5 clk = ~clk;

  can_tx_fifo dut (
    .clk(clk), .rst(rst), .reset_mode(reset_mode), .wr(wr), .data_in(data_in),
    .commit(commit), .tx_req(tx_req), .rd(rd), .data_out(data_out),
    .last_word(last_word), .tx_release(tx_release), .tx_rewind(tx_rewind),
    .overrun(overrun), .info_cnt(info_cnt), .free_words(free_words),
    .tx_state_o(tx_state_o)
  );

  function automatic void model_clear();
    exp_q.delete(); stg_q.delete(); len_q.delete();
    m_drop = 0; m_ovr = 0; m_off = 0;
  endfunction

  function automatic int m_free();
    return 64 - exp_q.size() - stg_q.size();
  endfunction

  function automatic void model_apply(bit w, logic [31:0] d, bit c, bit r, bit rel, bit rew, bit rm);
    int  free, n_info, n;
    bit  txr;
    if (rm) begin
      model_clear();
      return;
    end
    free   = m_free();
    n_info = len_q.size();
    txr    = (n_info != 0);
    if (w && free > 0 && stg_q.size() < 18 && !m_drop) stg_q.push_back(d);
    else if (w) begin m_drop = 1; m_ovr = 1; end
    if (txr && rel) begin
      n = len_q.pop_front();
      repeat (n) void'(exp_q.pop_front());
      m_off = 0;
    end else if (txr && rew) m_off = 0;
    else if (txr && r && m_off < len_q[0] - 1) m_off++;
    if (c) begin
      if (m_drop || (stg_q.size() != 0 && n_info == 16)) begin
        stg_q.delete(); m_drop = 0; m_ovr = 1;
      end else if (stg_q.size() != 0) begin
        len_q.push_back(stg_q.size());
        foreach (stg_q[i]) exp_q.push_back(stg_q[i]);
        stg_q.delete();
      end
    end
  endfunction

  task automatic step(input bit w, input logic [31:0] d, input bit c, input bit r,
                      input bit rel, input bit rew, input bit rm);
    wr = w; data_in = d; commit = c; rd = r; tx_release = rel; tx_rewind = rew; reset_mode = rm;
    @(posedge clk);
    model_apply(w, d, c, r, rel, rew, rm);
    #1;
    wr = 0; commit = 0; rd = 0; tx_release = 0; tx_rewind = 0; reset_mode = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++; if (tx_req !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_req: got %0b want 0", tx_req); end
    cmp_cnt++; if (info_cnt !== 5'd0) begin err_cnt++; $display("FAIL reset_info_cnt: got %0d want 0", info_cnt); end
    cmp_cnt++; if (free_words !== 7'd64) begin err_cnt++; $display("FAIL reset_free: got %0d want 64", free_words); end
    cmp_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    cmp_cnt++; if (tx_state_o !== TX_IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d want %0d", tx_state_o, TX_IDLE); end
  endtask

  task automatic test_basic();
    logic [31:0] w[3];
    do_reset();
    foreach (w[i]) begin w[i] = $urandom(); step(1, w[i], 0, 0, 0, 0, 0); end
    cmp_cnt++; if (free_words !== 7'd61) begin err_cnt++; $display("FAIL basic_staged_free: got %0d want 61", free_words); end
    step(0, 0, 1, 0, 0, 0, 0);
    cmp_cnt++; if (tx_req !== 1'b1 || info_cnt !== 5'd1) begin err_cnt++; $display("FAIL basic_commit: got req=%0b info=%0d want req=1 info=1", tx_req, info_cnt); end
    cmp_cnt++; if (data_out !== w[0] || last_word !== 1'b0) begin err_cnt++; $display("FAIL basic_word0: got %h last=%0b want %h last=0", data_out, last_word, w[0]); end
    step(0, 0, 0, 1, 0, 0, 0);
    cmp_cnt++; if (data_out !== w[1]) begin err_cnt++; $display("FAIL basic_word1: got %h want %h", data_out, w[1]); end
    step(0, 0, 0, 1, 0, 0, 0);
    cmp_cnt++; if (data_out !== w[2] || last_word !== 1'b1) begin err_cnt++; $display("FAIL basic_word2: got %h last=%0b want %h last=1", data_out, last_word, w[2]); end
    step(0, 0, 0, 0, 1, 0, 0);
    cmp_cnt++; if (tx_req !== 1'b0 || free_words !== 7'd64 || info_cnt !== 5'd0) begin err_cnt++; $display("FAIL basic_release: got req=%0b free=%0d info=%0d want 0/64/0", tx_req, free_words, info_cnt); end
  endtask

  task automatic test_rewind();
    logic [31:0] w0, w1;
    do_reset();
    w0 = $urandom(); w1 = $urandom();
    step(1, w0, 0, 0, 0, 0, 0);
    step(1, w1, 1, 0, 0, 0, 0);
    cmp_cnt++; if (info_cnt !== 5'd1 || data_out !== w0) begin err_cnt++; $display("FAIL rew_commit_same_cycle: got info=%0d data=%h want 1 %h", info_cnt, data_out, w0); end
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    cmp_cnt++; if (data_out !== w1 || last_word !== 1'b1 || tx_state_o !== TX_DONE_WAIT) begin err_cnt++; $display("FAIL rew_saturate: got %h last=%0b st=%0d want %h 1 %0d", data_out, last_word, tx_state_o, w1, TX_DONE_WAIT); end
    step(0, 0, 0, 0, 0, 1, 0);
    cmp_cnt++; if (data_out !== w0 || tx_state_o !== TX_READY || last_word !== 1'b0) begin err_cnt++; $display("FAIL rew_rewind: got %h st=%0d last=%0b want %h %0d 0", data_out, tx_state_o, last_word, w0, TX_READY); end
    step(0, 0, 0, 1, 0, 0, 0);
    cmp_cnt++; if (data_out !== w1) begin err_cnt++; $display("FAIL rew_reread: got %h want %h", data_out, w1); end
    step(0, 0, 0, 0, 1, 0, 0);
    cmp_cnt++; if (info_cnt !== 5'd0 || tx_req !== 1'b0) begin err_cnt++; $display("FAIL rew_release: got info=%0d req=%0b want 0 0", info_cnt, tx_req); end
  endtask

  task automatic test_overrun_len();
    logic [31:0] x;
    do_reset();
    repeat (18) step(1, $urandom(), 0, 0, 0, 0, 0);
    cmp_cnt++; if (free_words !== 7'd46 || overrun !== 1'b0) begin err_cnt++; $display("FAIL ovl_18: got free=%0d ovr=%0b want 46 0", free_words, overrun); end
    step(1, $urandom(), 0, 0, 0, 0, 0);
    cmp_cnt++; if (overrun !== 1'b1 || free_words !== 7'd46) begin err_cnt++; $display("FAIL ovl_19th: got ovr=%0b free=%0d want 1 46", overrun, free_words); end
    step(0, 0, 1, 0, 0, 0, 0);
    cmp_cnt++; if (overrun !== 1'b1 || info_cnt !== 5'd0 || free_words !== 7'd64 || tx_req !== 1'b0) begin err_cnt++; $display("FAIL ovl_discard: got ovr=%0b info=%0d free=%0d req=%0b want 1 0 64 0", overrun, info_cnt, free_words, tx_req); end
    step(0, 0, 0, 0, 0, 0, 1);
    cmp_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovl_reset_mode: got %0b want 0", overrun); end
    x = $urandom();
    step(1, x, 1, 0, 0, 0, 0);
    cmp_cnt++; if (info_cnt !== 5'd1 || data_out !== x) begin err_cnt++; $display("FAIL ovl_recover: got info=%0d data=%h want 1 %h", info_cnt, data_out, x); end
  endtask

  task automatic test_fill();
    logic [31:0] first[4];
    logic [31:0] d;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom();
        if (i == 0) first[f] = d;
        step(1, d, 0, 0, 0, 0, 0);
      end
      step(0, 0, 1, 0, 0, 0, 0);
    end
    cmp_cnt++; if (info_cnt !== 5'd4 || free_words !== 7'd0 || data_out !== first[0]) begin err_cnt++; $display("FAIL fill_full: got info=%0d free=%0d data=%h want 4 0 %h", info_cnt, free_words, data_out, first[0]); end
    step(1, $urandom(), 0, 0, 0, 0, 0);
    cmp_cnt++; if (overrun !== 1'b1 || free_words !== 7'd0) begin err_cnt++; $display("FAIL fill_overrun: got ovr=%0b free=%0d want 1 0", overrun, free_words); end
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, $urandom(), 0, 0, 1, 0, 0);
    cmp_cnt++; if (info_cnt !== 5'd3 || free_words !== 7'd16 || data_out !== first[1]) begin err_cnt++; $display("FAIL fill_release_wr: got info=%0d free=%0d data=%h want 3 16 %h", info_cnt, free_words, data_out, first[1]); end
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, $urandom(), 0, 0, 0, 0, 0);
    cmp_cnt++; if (free_words !== 7'd15) begin err_cnt++; $display("FAIL fill_next_wr: got %0d want 15", free_words); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f1w0;
    do_reset();
    step(1, $urandom(), 0, 0, 0, 0, 0);
    step(1, $urandom(), 1, 0, 0, 0, 0);
    f1w0 = $urandom();
    step(1, f1w0, 0, 0, 0, 0, 0);
    step(1, $urandom(), 1, 0, 0, 0, 0);
    step(1, $urandom(), 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    cmp_cnt++; if (info_cnt !== 5'd2 || free_words !== 7'd61 || data_out !== f1w0) begin err_cnt++; $display("FAIL b2b_commit_release: got info=%0d free=%0d data=%h want 2 61 %h", info_cnt, free_words, data_out, f1w0); end
  endtask

  task automatic test_wrap();
    logic [31:0] w[18];
    do_reset();
    repeat (3) begin
      repeat (16) step(1, $urandom(), 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
    end
    foreach (w[i]) begin w[i] = $urandom(); step(1, w[i], 0, 0, 0, 0, 0); end
    step(0, 0, 1, 0, 0, 0, 0);
    cmp_cnt++; if (free_words !== 7'd46) begin err_cnt++; $display("FAIL wrap_free: got %0d want 46", free_words); end
    for (int i = 0; i < 18; i++) begin
      cmp_cnt++; if (data_out !== w[i] || last_word !== (i == 17)) begin err_cnt++; $display("FAIL wrap_word%0d: got %h last=%0b want %h last=%0b", i, data_out, last_word, w[i], i == 17); end
      step(0, 0, 0, 1, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    cmp_cnt++; if (free_words !== 7'd64 || tx_req !== 1'b0) begin err_cnt++; $display("FAIL wrap_release: got free=%0d req=%0b want 64 0", free_words, tx_req); end
  endtask

  task automatic test_reset_mode_mid();
    logic [31:0] w[10];
    logic [31:0] z;
    do_reset();
    foreach (w[i]) begin w[i] = $urandom(); step(1, w[i], 0, 0, 0, 0, 0); end
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 0, 0, 0);
    cmp_cnt++; if (data_out !== w[5]) begin err_cnt++; $display("FAIL rm_offset5: got %h want %h", data_out, w[5]); end
    step(0, 0, 0, 0, 0, 0, 1);
    cmp_cnt++; if (tx_req !== 1'b0 || free_words !== 7'd64 || info_cnt !== 5'd0 || tx_state_o !== TX_IDLE) begin err_cnt++; $display("FAIL rm_clear: got req=%0b free=%0d info=%0d st=%0d want 0 64 0 0", tx_req, free_words, info_cnt, tx_state_o); end
    z = $urandom();
    step(1, z, 1, 0, 0, 0, 0);
    cmp_cnt++; if (data_out !== z || info_cnt !== 5'd1 || last_word !== 1'b1) begin err_cnt++; $display("FAIL rm_restart: got %h info=%0d last=%0b want %h 1 1", data_out, info_cnt, last_word, z); end
  endtask

  task automatic test_random();
    bit          w, c, r, rel, rew, rm, e_req, e_last;
    logic [31:0] e_data;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      w   = ($urandom_range(0, 99) < 60);
      c   = ($urandom_range(0, 99) < 15);
      r   = ($urandom_range(0, 99) < 40);
      rel = ($urandom_range(0, 99) < 7);
      rew = ($urandom_range(0, 99) < 4);
      rm  = ($urandom_range(0, 499) == 0);
      step(w, $urandom(), c, r, rel, rew, rm);
      e_req = (len_q.size() != 0);
      cmp_cnt++; if (tx_req !== e_req || info_cnt !== 5'(len_q.size()) || free_words !== 7'(m_free()) || overrun !== m_ovr) begin
        err_cnt++; $display("FAIL rand_status@%0d: got req=%0b info=%0d free=%0d ovr=%0b want %0b %0d %0d %0b",
                            n, tx_req, info_cnt, free_words, overrun, e_req, len_q.size(), m_free(), m_ovr);
      end
      if (e_req) begin
        e_data = exp_q[m_off];
        e_last = (m_off == len_q[0] - 1);
        cmp_cnt++; if (data_out !== e_data || last_word !== e_last) begin
          err_cnt++; $display("FAIL rand_data@%0d: got %h last=%0b want %h last=%0b", n, data_out, last_word, e_data, e_last);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_rewind();
    test_overrun_len();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_reset_mode_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
